seg_dp_update: RTL and testbench

// Consumes the Emin(j,i) stream from emin for one target index i and runs one row of the

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_dp_update_if.sv | 41 ++++
 rtl/seg_dp_update.sv | 168 ++++++++++++++++
 tb/tb_seg_dp_update.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared types and helpers for the segmentation DP blocks.
//   dp_state_t : row FSM states (IDLE, RUN, DRAIN)
//   COST_W     : signed cost/energy width used by the datapath
//   COST_MAX / COST_MIN : saturation limits of the signed cost range
//   sat_add    : signed add, clamped to the COST_W range
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dp_state_t;

    localparam int COST_W = 32;

    typedef logic signed [COST_W-1:0] cost_t;
    // Two guard bits: holds the exact sum of three cost-width operands.
    typedef logic signed [COST_W+1:0] wide_t;

    localparam cost_t COST_MAX = {1'b0, {(COST_W-1){1'b1}}};
    localparam cost_t COST_MIN = {1'b1, {(COST_W-1){1'b0}}};

    // Operands are passed wide so a caller can fold several terms into one
    // exact sum and clamp only once at the end.
    function automatic cost_t sat_add(input wide_t a, input wide_t b);
        wide_t s;
        s = a + b;
        if (s > wide_t'(COST_MAX)) begin
            return COST_MAX;
        end else if (s < wide_t'(COST_MIN)) begin
            return COST_MIN;
        end else begin
            return cost_t'(s[COST_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/seg_dp_update_if.sv
// -----------------------------------------------------------------------------
// seg_dp_update_if
// Bundles the row-control, Emin stream and cost/backpointer BRAM signals of
// seg_dp_update.
//   slave  : the DP block (consumes start/stream/rdata, drives BRAM + status)
//   master : the surrounding sequencer / emin / BRAM side
// -----------------------------------------------------------------------------
interface seg_dp_update_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160
);
    localparam int AW = $clog2(I);

    logic                        start_in;
    logic [AW-1:0]               i_in;
    logic [AW-1:0]               emin_j_in;
    logic signed [BIT_WIDTH-1:0] emin_data_in;
    logic                        emin_valid_in;
    logic [AW-1:0]               cost_raddr_out;
    logic signed [BIT_WIDTH-1:0] cost_rdata_in;
    logic                        cost_we_out;
    logic [AW-1:0]               cost_waddr_out;
    logic signed [BIT_WIDTH-1:0] cost_wdata_out;
    logic [AW-1:0]               bp_wdata_out;
    logic                        done_out;
    logic                        busy_out;
    logic                        err_out;

    modport slave (
        input  start_in, i_in, emin_j_in, emin_data_in, emin_valid_in, cost_rdata_in,
        output cost_raddr_out, cost_we_out, cost_waddr_out, cost_wdata_out,
               bp_wdata_out, done_out, busy_out, err_out
    );

    modport master (
        output start_in, i_in, emin_j_in, emin_data_in, emin_valid_in, cost_rdata_in,
        input  cost_raddr_out, cost_we_out, cost_waddr_out, cost_wdata_out,
               bp_wdata_out, done_out, busy_out, err_out
    );

endinterface

// File: rtl/seg_dp_update.sv
// -----------------------------------------------------------------------------
// seg_dp_update
// One row of the segmentation DP for target index i:
//   OPT(i) = min_{j in [0,i]} OPT(j-1) + Emin(j,i) + PENALTY, OPT(-1) = 0
// Consumes the Emin(j,i) stream, reads OPT(j-1) from the cost BRAM (2-cycle
// read latency), and writes OPT(i) with its argmin j as the backpointer.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (slave)    : start_in/i_in, emin_j_in/emin_data_in/emin_valid_in,
//                    cost_raddr_out/cost_rdata_in, cost_we_out/cost_waddr_out/
//                    cost_wdata_out/bp_wdata_out, done_out, busy_out, err_out
// The datapath width comes from seg_pkg::COST_W; BIT_WIDTH must equal it.
// -----------------------------------------------------------------------------
module seg_dp_update
    import seg_pkg::*;
#(
    parameter int BIT_WIDTH = COST_W,
    parameter int I         = 160,
    parameter int PENALTY   = 0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    seg_dp_update_if.slave  bus
);
    localparam int AW = $clog2(I);
    typedef logic [AW-1:0]               idx_t;
    typedef logic signed [BIT_WIDTH-1:0] data_t;
    localparam data_t PEN = data_t'(PENALTY);

    dp_state_t state_q;
    idx_t      i_q, exp_j_q;
    logic      err_q, busy_q, we_q, done_q;
    data_t     best_cost_q, wdata_q;
    idx_t      best_j_q, bp_q;

    // Delay line covering the BRAM read latency (stages 1 and 2).
    logic      v1_q, v2_q, z1_q, z2_q, l1_q, l2_q;
    idx_t      j1_q, j2_q;
    data_t     d1_q, d2_q;

    // Stage 3: registered candidate waiting for the compare.
    logic      v3_q, l3_q;
    idx_t      j3_q;
    data_t     cand_q;

    logic      accept;
    logic      is_last;
    data_t     prev;
    data_t     cand_d;
    logic      take;
    data_t     best_cost_d;
    idx_t      best_j_d;

    assign accept  = (state_q == RUN) && bus.emin_valid_in;
    assign is_last = (bus.emin_j_in == i_q);

    // Address for j==0 wraps and is never used: the zero flag forces prev=0.
    assign bus.cost_raddr_out = (state_q == RUN) ? (bus.emin_j_in - idx_t'(1)) : '0;

    always_comb begin
        prev        = z2_q ? data_t'(0) : data_t'(bus.cost_rdata_in);
        // One exact three-term sum, clamped once.
        cand_d      = data_t'(sat_add(wide_t'(prev), wide_t'(d2_q) + wide_t'(PEN)));
        // Strict compare so a tie keeps the earlier (smaller) j.
        take        = v3_q && (cand_q < best_cost_q);
        best_cost_d = take ? cand_q : best_cost_q;
        best_j_d    = take ? j3_q : best_j_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            i_q         <= '0;
            exp_j_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            best_cost_q <= data_t'(COST_MAX);
            best_j_q    <= '0;
            wdata_q     <= '0;
            bp_q        <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            z1_q        <= 1'b0;
            z2_q        <= 1'b0;
            l1_q        <= 1'b0;
            l2_q        <= 1'b0;
            l3_q        <= 1'b0;
            j1_q        <= '0;
            j2_q        <= '0;
            j3_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            cand_q      <= '0;
        end else begin
            v1_q   <= accept;
            l1_q   <= accept && is_last;
            z1_q   <= (bus.emin_j_in == '0);
            j1_q   <= bus.emin_j_in;
            d1_q   <= bus.emin_data_in;
            v2_q   <= v1_q;
            l2_q   <= l1_q;
            z2_q   <= z1_q;
            j2_q   <= j1_q;
            d2_q   <= d1_q;
            v3_q   <= v2_q;
            l3_q   <= l2_q;
            j3_q   <= j2_q;
            cand_q <= cand_d;

            best_cost_q <= best_cost_d;
            best_j_q    <= best_j_d;

            we_q   <= 1'b0;
            done_q <= 1'b0;
            // The write carries the best after the j==i candidate is folded in.
            if (v3_q && l3_q) begin
                we_q    <= 1'b1;
                done_q  <= 1'b1;
                wdata_q <= best_cost_d;
                bp_q    <= best_j_d;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start_in) begin
                        state_q     <= RUN;
                        i_q         <= bus.i_in;
                        exp_j_q     <= '0;
                        best_cost_q <= data_t'(COST_MAX);
                        best_j_q    <= '0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        exp_j_q <= exp_j_q + idx_t'(1);
                        if (bus.emin_j_in != exp_j_q) begin
                            err_q <= 1'b1;
                        end
                        if (is_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cost_we_out    = we_q;
    assign bus.cost_waddr_out = i_q;
    assign bus.cost_wdata_out = wdata_q;
    assign bus.bp_wdata_out   = bp_q;
    assign bus.done_out       = done_q;
    assign bus.busy_out       = busy_q;
    assign bus.err_out        = err_q;

endmodule

// File: tb/tb_seg_dp_update.sv
module tb_seg_dp_update;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Two instances with different penalties driven by the same stream.
    seg_dp_update_if #(.BIT_WIDTH(32), .I(160)) if0 ();
    seg_dp_update_if #(.BIT_WIDTH(32), .I(160)) if2 ();

    seg_dp_update #(.BIT_WIDTH(32), .I(160), .PENALTY(0)) dut0 (
        .clk_in(clk), .rst_in(rst), .bus(if0.slave));
    seg_dp_update #(.BIT_WIDTH(32), .I(160), .PENALTY(2)) dut2 (
        .clk_in(clk), .rst_in(rst), .bus(if2.slave));

    assign if2.start_in      = if0.start_in;
    assign if2.i_in          = if0.i_in;
    assign if2.emin_j_in     = if0.emin_j_in;
    assign if2.emin_data_in  = if0.emin_data_in;
    assign if2.emin_valid_in = if0.emin_valid_in;

    // Cost BRAM model: 2-cycle read latency, one read pipe per instance.
    logic signed [31:0] opt_mem [0:255];
    logic signed [31:0] rd0_p1, rd0_p2, rd2_p1, rd2_p2;
    initial begin
        rd0_p1 = '0; rd0_p2 = '0; rd2_p1 = '0; rd2_p2 = '0;
        forever begin
            @(posedge clk);
            rd0_p2 <= rd0_p1;
            rd0_p1 <= opt_mem[if0.cost_raddr_out];
            rd2_p2 <= rd2_p1;
            rd2_p1 <= opt_mem[if2.cost_raddr_out];
        end
    end
    assign if0.cost_rdata_in = rd0_p2;
    assign if2.cost_rdata_in = rd2_p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]       i;
        int               n;
        logic [4:0][7:0]  j;
        logic [4:0][31:0] d;
        logic [4:0][1:0]  gap;
        logic             junk;   // stray sample while idle (must be ignored)
        logic             poke;   // stray start mid-row (must be ignored)
        logic [31:0]      c0;
        logic [7:0]       b0;
        logic [31:0]      c2;
        logic [7:0]       b2;
        logic             e;
    } vec_t;
    vec_t vecs [8];

    task automatic set_v(input int v, input int i, input int n, input logic [31:0] c0, input int b0,
                         input logic [31:0] c2, input int b2, input logic e, input logic junk,
                         input logic poke);
        vecs[v].i = 8'(i); vecs[v].n = n;
        vecs[v].c0 = c0; vecs[v].b0 = 8'(b0);
        vecs[v].c2 = c2; vecs[v].b2 = 8'(b2);
        vecs[v].e = e; vecs[v].junk = junk; vecs[v].poke = poke;
        vecs[v].j = '0; vecs[v].d = '0; vecs[v].gap = '0;
    endtask

    task automatic set_s(input int v, input int k, input int jj, input logic [31:0] dd, input int g);
        vecs[v].j[k]   = 8'(jj);
        vecs[v].d[k]   = dd;
        vecs[v].gap[k] = 2'(g);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] cost;
        logic [7:0]  bp;
        logic [7:0]  addr;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q2[$];
    int   writes_seen;

    task automatic cmp_write(input string p, input exp_t e, input logic we, input logic done,
                             input logic [31:0] cost, input logic [7:0] bp,
                             input logic [7:0] addr, input logic err);
        $display("%s write: addr=%0d cost=0x%08h bp=%0d err=%0d cyc=%0d", p, addr, cost, bp, err, cyc);
        chk({p, "_we"},   32'(we),   32'd1);
        chk({p, "_done"}, 32'(done), 32'd1);
        chk({p, "_cost"}, cost,      e.cost);
        chk({p, "_bp"},   32'(bp),   32'(e.bp));
        chk({p, "_addr"}, 32'(addr), 32'(e.addr));
        chk({p, "_err"},  32'(err),  32'(e.err));
        chk({p, "_lat"},  32'(cyc),  32'(e.cyc));
    endtask

    initial begin
        exp_t e;
        logic pend;
        logic pend_err;
        pend = 1'b0;
        pend_err = 1'b0;
        writes_seen = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("busy_drop0", 32'(if0.busy_out), 32'd0);
                chk("busy_drop2", 32'(if2.busy_out), 32'd0);
                chk("err_hold",   32'(if0.err_out),  32'(pend_err));
                pend = 1'b0;
            end
            if (if0.cost_we_out === 1'b1 || if0.done_out === 1'b1) begin
                writes_seen++;
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write0: got write addr=%0d expected none", if0.cost_waddr_out);
                end else begin
                    e = q0.pop_front();
                    cmp_write("p0", e, if0.cost_we_out, if0.done_out, if0.cost_wdata_out,
                              if0.bp_wdata_out, if0.cost_waddr_out, if0.err_out);
                    pend = 1'b1;
                    pend_err = e.err;
                end
            end
            if (if2.cost_we_out === 1'b1 || if2.done_out === 1'b1) begin
                writes_seen++;
                if (q2.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write2: got write addr=%0d expected none", if2.cost_waddr_out);
                end else begin
                    e = q2.pop_front();
                    cmp_write("p2", e, if2.cost_we_out, if2.done_out, if2.cost_wdata_out,
                              if2.bp_wdata_out, if2.cost_waddr_out, if2.err_out);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle_inputs();
        if0.start_in = 1'b0; if0.emin_valid_in = 1'b0;
        if0.emin_j_in = '0;  if0.emin_data_in = '0;
    endtask

    // Present a row's samples; returns the cycle of the last sample.
    task automatic drive_row(input int v, output int t_last);
        t_last = 0;
        @(posedge clk); #1;
        if0.start_in = 1'b1; if0.i_in = vecs[v].i;
        @(posedge clk); #1;
        if0.start_in = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(if0.busy_out), 32'd1);
        chk("err_after_start",  32'(if0.err_out),  32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < vecs[v].n; k++) begin
            for (int g = 0; g < int'(vecs[v].gap[k]); g++) begin
                if0.emin_valid_in = 1'b0;
                if (vecs[v].poke && k == 0 && g == 0) begin
                    if0.start_in = 1'b1; if0.i_in = 8'd7;
                end
                @(posedge clk); #1;
                if0.start_in = 1'b0; if0.i_in = vecs[v].i;
            end
            if0.emin_valid_in = 1'b1;
            if0.emin_j_in     = vecs[v].j[k];
            if0.emin_data_in  = vecs[v].d[k];
            t_last = cyc;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic run_vec(input int v);
        int   t_last;
        int   n;
        exp_t e;
        if (vecs[v].junk) begin
            @(posedge clk); #1;
            if0.emin_valid_in = 1'b1; if0.emin_j_in = '0; if0.emin_data_in = -32'sd1000;
            @(posedge clk); #1;
            idle_inputs();
        end
        drive_row(v, t_last);
        e.addr = vecs[v].i; e.err = vecs[v].e; e.cyc = t_last + 4;
        e.cost = vecs[v].c0; e.bp = vecs[v].b0; q0.push_back(e);
        e.cost = vecs[v].c2; e.bp = vecs[v].b2; q2.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (if0.done_out !== 1'b1 && n < 20);
        if (if0.done_out !== 1'b1) begin
            checks++; failures++;
            $display("FAIL done_timeout vec%0d: got no done expected done within 20 cycles", v);
            q0.delete(); q2.delete();
        end
    endtask

    initial begin
        int wsnap;
        int t_last;
        checks = 0; failures = 0;
        for (int a = 0; a < 256; a++) opt_mem[a] = '0;
        opt_mem[0] = 32'd3;
        opt_mem[1] = 32'd1;
        opt_mem[2] = 32'h7FFF_FFF0;
        opt_mem[3] = 32'h8000_0010;

        //     v  i  n  c0            b0 c2            b2 e     junk  poke
        set_v(0, 0, 1, 32'd5,        0, 32'd7,        0, 1'b0, 1'b1, 1'b0);
        set_s(0, 0, 0, 32'd5, 0);
        set_v(1, 2, 3, 32'd7,        1, 32'd9,        1, 1'b0, 1'b0, 1'b0);
        set_s(1, 0, 0, 32'd10, 0); set_s(1, 1, 1, 32'd4, 0); set_s(1, 2, 2, 32'd6, 0);
        set_v(2, 2, 3, 32'd7,        1, 32'd9,        1, 1'b0, 1'b0, 1'b1);
        set_s(2, 0, 0, 32'd10, 1); set_s(2, 1, 1, 32'd4, 2); set_s(2, 2, 2, 32'd6, 3);
        set_v(3, 3, 4, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 1'b0, 1'b0, 1'b0);
        set_s(3, 0, 0, 32'h7FFFFFFF, 0); set_s(3, 1, 1, 32'h7FFFFFFF, 0);
        set_s(3, 2, 2, 32'h7FFFFFFF, 0); set_s(3, 3, 3, 32'h100, 0);
        set_v(4, 4, 5, 32'h80000000, 4, 32'h80000000, 4, 1'b0, 1'b0, 1'b0);
        set_s(4, 0, 0, 32'd0, 0); set_s(4, 1, 1, 32'd0, 0); set_s(4, 2, 2, 32'd0, 0);
        set_s(4, 3, 3, 32'd0, 0); set_s(4, 4, 4, 32'hFFFFFF00, 0);
        set_v(5, 2, 2, 32'd1,        0, 32'd3,        0, 1'b1, 1'b0, 1'b0);
        set_s(5, 0, 0, 32'd1, 0); set_s(5, 1, 2, 32'd1, 0);
        set_v(6, 1, 2, 32'd7,        0, 32'd9,        0, 1'b0, 1'b0, 1'b0);
        set_s(6, 0, 0, 32'd7, 0); set_s(6, 1, 1, 32'd4, 0);
        set_v(7, 2, 3, 32'hFFFFFFE3, 2, 32'hFFFFFFE5, 2, 1'b0, 1'b0, 1'b0);
        set_s(7, 0, 0, -32'sd5, 0); set_s(7, 1, 1, -32'sd20, 0); set_s(7, 2, 2, -32'sd30, 0);

        // Reset state.
        idle_inputs();
        if0.i_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we",    32'(if0.cost_we_out),    32'd0);
        chk("rst_done",  32'(if0.done_out),       32'd0);
        chk("rst_busy",  32'(if0.busy_out),       32'd0);
        chk("rst_err",   32'(if0.err_out),        32'd0);
        chk("rst_wdata", if0.cost_wdata_out,      32'd0);
        chk("rst_waddr", 32'(if0.cost_waddr_out), 32'd0);
        chk("rst_bp",    32'(if0.bp_wdata_out),   32'd0);
        chk("rst_raddr", 32'(if0.cost_raddr_out), 32'd0);
        chk("rst_busy2", 32'(if2.busy_out),       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table vectors, rows back to back.
        for (int v = 0; v < 8; v++) begin
            $display("vec %0d: i=%0d samples=%0d", v, vecs[v].i, vecs[v].n);
            run_vec(v);
        end

        // Reset two cycles after the j==i sample: no write, busy drops next cycle.
        wsnap = writes_seen;
        drive_row(1, t_last);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy0", 32'(if0.busy_out), 32'd0);
        chk("rst_mid_busy2", 32'(if2.busy_out), 32'd0);
        repeat (10) @(negedge clk);
        chk("rst_mid_nowrite", 32'(writes_seen), 32'(wsnap));
        $display("mid-row reset: writes after reset=%0d", writes_seen - wsnap);

        // Recovery after the aborted row.
        run_vec(1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
